divider_seq: RTL and testbench

- Iterative restoring divider; the inverse operation of the DSP-partitioned 56x56 multiplier.
- Takes a 2N-bit product-width dividend and an N-bit divisor. Returns a 2N-bit quotient and an N-bit remainder.
- Used in the modular-reduction datapath to produce and check the quotient terms that the multiplier's upper and middle slices feed into.
- Valid/ready handshake on both input and output sides; one operation in flight at a time.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/div_step.sv | 21 ++
 rtl/divider_seq.sv | 114 +++++++++++
 tb/tb_divider_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and iteration constants for the sequential restoring divider.
// DIVIDER_RADIX4_EN selects two restoring steps per cycle instead of one.
package divider_pkg;

  localparam int DIV_SIZE = 56;

`ifdef DIVIDER_RADIX4_EN
  localparam int STEPS_PER_CYCLE = 2;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif

  localparam int ITER  = 2 * DIV_SIZE / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on an (N+1)-bit partial remainder.
// Zero latency; no flow control.
module div_step #(
  parameter int div_size = 56
) (
  input  logic [div_size:0]   rem_in,
  input  logic                dvd_bit,
  input  logic [div_size-1:0] divisor,
  output logic [div_size:0]   rem_out,
  output logic                q_bit
);

  logic [div_size+1:0] trial;

  // rem_in < divisor, so the shifted value is < 2^(N+1) and the sign of the
  // trial difference lands cleanly in bit N+1.
  assign trial   = {rem_in, dvd_bit} - {2'b00, divisor};
  assign q_bit   = ~trial[div_size+1];
  assign rem_out = q_bit ? trial[div_size:0] : (div_size+1)'({rem_in, dvd_bit});

endmodule

// File: rtl/divider_seq.sv
// Iterative 2N/N restoring divider, one op in flight; result ITER+1 cycles after accept (1 for /0).
// in_ready only in IDLE with nothing latched; result held in DONE until out_ready. Macro: DIVIDER_RADIX4_EN.
module divider_seq
  import divider_pkg::*;
#(
  parameter int div_size = DIV_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*div_size-1:0] dividend,
  input  logic [div_size-1:0]   divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*div_size-1:0] quotient,
  output logic [div_size-1:0]   remainder,
  output logic                  div_zero
);

  localparam int QW      = 2 * div_size;
  localparam int ITER_N  = QW / STEPS_PER_CYCLE;
  localparam int CNT_W_N = $clog2(ITER_N);

  state_t                     state_q, state_d;
  logic                       load_q;
  logic [CNT_W_N-1:0]         cnt_q;
  logic [QW-1:0]              shift_q;
  logic [div_size-1:0]        dvs_q;
  logic [div_size:0]          rem_q, rem_nxt;
  logic [STEPS_PER_CYCLE-1:0] q_bits;
  logic                       dz_q;

  assign in_ready  = (state_q == IDLE) && !load_q;
  assign out_valid = (state_q == DONE);
  assign quotient  = shift_q;
  assign remainder = div_size'(rem_q);
  assign div_zero  = dz_q;

`ifdef DIVIDER_RADIX4_EN
  logic [div_size:0] rem_mid;

  div_step #(.div_size(div_size)) u_step_hi (
    .rem_in (rem_q),
    .dvd_bit(shift_q[QW-1]),
    .divisor(dvs_q),
    .rem_out(rem_mid),
    .q_bit  (q_bits[1])
  );

  div_step #(.div_size(div_size)) u_step_lo (
    .rem_in (rem_mid),
    .dvd_bit(shift_q[QW-2]),
    .divisor(dvs_q),
    .rem_out(rem_nxt),
    .q_bit  (q_bits[0])
  );
`else
  div_step #(.div_size(div_size)) u_step (
    .rem_in (rem_q),
    .dvd_bit(shift_q[QW-1]),
    .divisor(dvs_q),
    .rem_out(rem_nxt),
    .q_bit  (q_bits[0])
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_q) state_d = (dvs_q == '0) ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // shift_q holds the dividend on accept and fills with quotient bits as it
  // drains, so one register serves as both operand and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else if (in_valid && in_ready) begin
      load_q  <= 1'b1;
      shift_q <= dividend;
      dvs_q   <= divisor;
    end else if (load_q) begin
      load_q <= 1'b0;
      cnt_q  <= CNT_W_N'(ITER_N - 1);
      dz_q   <= (dvs_q == '0);
      if (dvs_q == '0) begin
        shift_q <= '1;
        rem_q   <= {1'b0, shift_q[div_size-1:0]};
      end else begin
        rem_q <= '0;
      end
    end else if (state_q == RUN) begin
      rem_q   <= rem_nxt;
      shift_q <= {shift_q[QW-1-STEPS_PER_CYCLE:0], q_bits};
      cnt_q   <= cnt_q - CNT_W_N'(1);
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: directed operands with hand-computed results.
module tb_divider_seq;

  localparam int N = 56;
`ifdef DIVIDER_RADIX4_EN
  localparam int LAT = 57;
`else
  localparam int LAT = 113;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_zero;

  divider_seq #(.div_size(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dz;
    int             acc;
    int             lat;
    int             hold;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_out_edge = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                       input logic [2*N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input int hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("accept_timeout", 1'b0, 1'b1);
    end else begin
      e.q = eq; e.r = er; e.dz = edz; e.acc = cyc + 1;
      e.lat = (dvs == '0) ? 1 : LAT;
      e.hold = hold;
      chk("accept_after_out", 112'(e.acc > last_out_edge), 112'd1);
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    dividend = '1;
    divisor  = 56'd5;
  endtask

  // Monitor: captures each result on its first valid cycle, optionally stalls it.
  exp_t            cur;
  bit              busy = 0;
  int              hold_left = 0;
  logic [2*N-1:0]  cap_q;
  logic [N-1:0]    cap_r;
  logic            cap_dz;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
      out_ready = 1'b1;
    end else if (out_valid) begin
      if (!busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 112'd1, 112'd0);
        end else begin
          cur = sb[0];
          busy = 1;
          hold_left = cur.hold;
          cap_q = quotient; cap_r = remainder; cap_dz = div_zero;
          chk("latency", 112'(cyc - cur.acc), 112'(cur.lat));
        end
      end else begin
        chk("hold_quotient", quotient, cap_q);
        chk("hold_remainder", 112'(remainder), 112'(cap_r));
        chk("hold_div_zero", 112'(div_zero), 112'(cap_dz));
      end
      chk("in_ready_in_done", 112'(in_ready), 112'd0);
      if (busy) begin
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = 1'b1;
          chk("quotient", quotient, cur.q);
          chk("remainder", 112'(remainder), 112'(cur.r));
          chk("div_zero", 112'(div_zero), 112'(cur.dz));
          void'(sb.pop_front());
          busy = 0;
          last_out_edge = cyc + 1;
        end
      end
    end
  end

  localparam logic [2*N-1:0] ALL1   = {(2*N){1'b1}};
  localparam logic [N-1:0]   MAXD   = {N{1'b1}};
  localparam logic [2*N-1:0] MAXSQ  = 112'hFFFFFFFFFFFFFE00000000000001;
  localparam logic [2*N-1:0] MAXSQ5 = 112'hFFFFFFFFFFFFFE00000000000006;

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 112'(in_ready), 112'd1);
    chk("rst_out_valid", 112'(out_valid), 112'd0);
    chk("rst_quotient", quotient, 112'd0);
    chk("rst_remainder", 112'(remainder), 112'd0);
    chk("rst_div_zero", 112'(div_zero), 112'd0);
    rst_n = 1'b1;

    issue(112'd100, 56'd7, 112'd14, 56'd2, 1'b0, 0);
    issue(ALL1, 56'd1, ALL1, 56'd0, 1'b0, 0);
    issue(MAXSQ, MAXD, 112'(MAXD), 56'd0, 1'b0, 0);
    issue(MAXSQ5, MAXD, 112'(MAXD), 56'd5, 1'b0, 0);
    issue(112'h1234_0000_0000_0000_ABCD, 56'd0, ALL1, 56'h0000000000ABCD, 1'b1, 0);
    issue(112'd5, 56'd9, 112'd0, 56'd5, 1'b0, 0);
    issue(112'h1_0000_0000_0000_0000, 56'd256, 112'h100_0000_0000_0000, 56'd0, 1'b0, 0);
    issue(ALL1, 56'h80_0000_0000_0000, 112'h1FF_FFFF_FFFF_FFFF, 56'h7F_FFFF_FFFF_FFFF, 1'b0, 0);
    // Stalled result followed at once by an op that must wait for the out handshake.
    issue(112'd12345, 56'd100, 112'd123, 56'd45, 1'b0, 5);
    issue(112'd1000, 56'd1000, 112'd1, 56'd0, 1'b0, 0);

    // Abort mid-RUN with an asynchronous reset.
    n = 0;
    while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
    issue(ALL1, 56'd3, ALL1, 56'd0, 1'b0, 0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 112'(out_valid), 112'd0);
    chk("abort_in_ready", 112'(in_ready), 112'd1);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(112'd100, 56'd7, 112'd14, 56'd2, 1'b0, 0);

    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 112'(sb.size()), 112'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
